// File: rtl/exe_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the EX stage.
// Owns HI/LO, interlocks HI/LO users while an operation is in flight.
module exe_muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EXE_valid,
    input  logic [5:0]  EXE_OP,
    input  logic [5:0]  EXE_Funct,
    input  logic [31:0] EXE_busA,
    input  logic [31:0] EXE_busB,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_rdata,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic        op_div;
    logic        op_signed;
    logic        sign_a;
    logic        sign_b;
    logic        div_zero;
    logic [31:0] opb;
    logic [63:0] acc;
    logic [31:0] hi;
    logic [31:0] lo;

    // Instruction decode
    logic special;
    logic is_mfhi;
    logic is_mthi;
    logic is_mflo;
    logic is_mtlo;
    logic is_mult;
    logic is_multu;
    logic is_div;
    logic is_divu;
    logic is_md;
    logic is_hilo;
    logic idle;
    logic accept;

    always_comb begin
        special  = EXE_valid & (EXE_OP == 6'h00);
        is_mfhi  = special & (EXE_Funct == FN_MFHI);
        is_mthi  = special & (EXE_Funct == FN_MTHI);
        is_mflo  = special & (EXE_Funct == FN_MFLO);
        is_mtlo  = special & (EXE_Funct == FN_MTLO);
        is_mult  = special & (EXE_Funct == FN_MULT);
        is_multu = special & (EXE_Funct == FN_MULTU);
        is_div   = special & (EXE_Funct == FN_DIV);
        is_divu  = special & (EXE_Funct == FN_DIVU);
        is_md    = is_mult | is_multu | is_div | is_divu;
        is_hilo  = is_md | is_mfhi | is_mthi | is_mflo | is_mtlo;
        idle     = (state == IDLE);
        accept   = is_md & idle;
    end

    assign md_busy  = ~idle;
    assign md_stall = is_hilo & ~idle;
    assign md_hi    = hi;
    assign md_lo    = lo;

    always_comb begin
        md_rdata = 32'h0;
        if (is_mfhi) begin
            md_rdata = hi;
        end else if (is_mflo) begin
            md_rdata = lo;
        end
    end

    // Operand preparation at accept time
    logic        in_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    always_comb begin
        in_signed = is_mult | is_div;
        abs_a     = EXE_busA;
        abs_b     = EXE_busB;
        if (in_signed & EXE_busA[31]) begin
            abs_a = 32'h0 - EXE_busA;
        end
        if (in_signed & EXE_busB[31]) begin
            abs_b = 32'h0 - EXE_busB;
        end
    end

    // One iteration step; acc low half starts as multiplier or dividend
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'h0);
        mul_next  = {mul_sum, acc[31:1]};
        div_trial = {acc[63:32], acc[31]};
        div_diff  = div_trial - {1'b0, opb};
        div_ge    = (div_trial >= {1'b0, opb});
        div_rem   = div_ge ? div_diff[31:0] : div_trial[31:0];
        div_next  = {div_rem, acc[30:0], div_ge};
    end

    // Sign correction of the finished magnitude result
    logic        neg_res;
    logic [63:0] mul_res;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    always_comb begin
        neg_res = op_signed & (sign_a ^ sign_b);
        mul_res = neg_res ? (64'h0 - acc) : acc;
        quo_res = acc[31:0];
        if (div_zero) begin
            quo_res = 32'hFFFF_FFFF;
        end else if (neg_res) begin
            quo_res = 32'h0 - acc[31:0];
        end
        // With a zero divisor this restores the latched rs value
        rem_res = (op_signed & sign_a) ? (32'h0 - acc[63:32]) : acc[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 5'd31) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 5'd0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            opb       <= 32'h0;
            acc       <= 64'h0;
        end else if (accept) begin
            cnt       <= 5'd0;
            op_div    <= is_div | is_divu;
            op_signed <= in_signed;
            sign_a    <= EXE_busA[31];
            sign_b    <= EXE_busB[31];
            div_zero  <= (EXE_busB == 32'h0);
            opb       <= abs_b;
            acc       <= {32'h0, abs_a};
        end else if (state == BUSY) begin
            cnt <= cnt + 5'd1;
            acc <= op_div ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'h0;
            lo <= 32'h0;
        end else if (state == FIX) begin
            if (op_div) begin
                hi <= rem_res;
                lo <= quo_res;
            end else begin
                hi <= mul_res[63:32];
                lo <= mul_res[31:0];
            end
        end else if (idle) begin
            if (is_mthi) begin
                hi <= EXE_busA;
            end
            if (is_mtlo) begin
                lo <= EXE_busA;
            end
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Randomized self-checking bench for exe_muldiv_unit against an
// arithmetic reference model of HI/LO results and pipeline timing.
module tb_exe_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        EXE_valid;
    logic [5:0]  EXE_OP;
    logic [5:0]  EXE_Funct;
    logic [31:0] EXE_busA;
    logic [31:0] EXE_busB;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    int checks = 0;
    int errors = 0;

    exe_muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EXE_valid (EXE_valid),
        .EXE_OP    (EXE_OP),
        .EXE_Funct (EXE_Funct),
        .EXE_busA  (EXE_busA),
        .EXE_busB  (EXE_busB),
        .md_busy   (md_busy),
        .md_stall  (md_stall),
        .md_rdata  (md_rdata),
        .md_hi     (md_hi),
        .md_lo     (md_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: results straight from integer arithmetic
    function automatic void model(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        logic signed [63:0] sp;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        hi = 0;
        lo = 0;
        case (f)
            6'h18: begin
                sp = 64'(sa) * 64'(sb);
                hi = sp[63:32];
                lo = sp[31:0];
            end
            6'h19: begin
                p = {32'h0, a} * {32'h0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            6'h1A: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        EXE_valid = v;
        EXE_OP    = op;
        EXE_Funct = f;
        EXE_busA  = a;
        EXE_busB  = b;
    endtask

    // Issue one mul/div, then bubbles; check latency and HI/LO
    task automatic run_md(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh;
        logic [31:0] el;
        int n;
        model(f, a, b, eh, el);
        drive(1'b1, 6'h00, f, a, b);
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        n = 0;
        while (md_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL %s latency got %0d want 33", name, n);
        end
        checks++;
        if (md_hi !== eh || md_lo !== el) begin
            errors++;
            $display("FAIL %s f=%h a=%h b=%h hi/lo got %h/%h want %h/%h",
                     name, f, a, b, md_hi, md_lo, eh, el);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        EXE_valid = 1'b0;
        EXE_OP    = 6'h00;
        EXE_Funct = 6'h00;
        EXE_busA  = 32'h0;
        EXE_busB  = 32'h0;
        #12;
        checks++;
        if (md_busy !== 1'b0 || md_stall !== 1'b0 ||
            md_hi !== 32'h0 || md_lo !== 32'h0) begin
            errors++;
            $display("FAIL reset busy=%b stall=%b hi=%h lo=%h want 0/0/0/0",
                     md_busy, md_stall, md_hi, md_lo);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        run_md("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (md_hi !== 32'hFFFF_FFFE || md_lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_const got %h/%h want fffffffe/00000001", md_hi, md_lo);
        end
        run_md("div_neg7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (md_hi !== 32'hFFFF_FFFF || md_lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_const got %h/%h want ffffffff/fffffffd", md_hi, md_lo);
        end
        run_md("divu_100_7", 6'h1B, 32'd100, 32'd7);
        checks++;
        if (md_hi !== 32'd2 || md_lo !== 32'd14) begin
            errors++;
            $display("FAIL divu_const got %h/%h want 2/14", md_hi, md_lo);
        end
        run_md("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("divu_zero", 6'h1B, 32'h0000_1234, 32'h0);
        run_md("div_zero_neg", 6'h1A, 32'hFFFF_FF00, 32'h0);
        run_md("mult_min", 6'h18, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_mflo_stall;
        int n;
        drive(1'b1, 6'h00, 6'h18, 32'hFFFF_FFFD, 32'd7);
        drive(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
        #1;
        n = 0;
        while (md_stall && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL mflo_stall cycles got %0d want 33", n);
        end
        checks++;
        if (md_rdata !== 32'hFFFF_FFEB || md_hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mflo_data rdata=%h hi=%h want ffffffeb/ffffffff",
                     md_rdata, md_hi);
        end
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    endtask

    task automatic test_mt_mf;
        drive(1'b1, 6'h00, 6'h11, 32'hA5A5_A5A5, 32'h0);
        drive(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
        #1;
        checks++;
        if (md_stall !== 1'b0 || md_rdata !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL mthi_mfhi stall=%b rdata=%h want 0/a5a5a5a5",
                     md_stall, md_rdata);
        end
        drive(1'b1, 6'h00, 6'h13, 32'h5A5A_0F0F, 32'h0);
        drive(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
        #1;
        checks++;
        if (md_rdata !== 32'h5A5A_0F0F || md_hi !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL mtlo_mflo rdata=%h hi=%h want 5a5a0f0f/a5a5a5a5",
                     md_rdata, md_hi);
        end
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    endtask

    task automatic test_ignored;
        drive(1'b0, 6'h00, 6'h18, 32'd3, 32'd3);
        drive(1'b1, 6'h23, 6'h18, 32'd3, 32'd3);
        #1;
        checks++;
        if (md_busy !== 1'b0 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL ignored busy=%b stall=%b want 0/0", md_busy, md_stall);
        end
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        #1;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_late busy=%b want 0", md_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] h1;
        logic [31:0] l1;
        logic [31:0] h2;
        logic [31:0] l2;
        int n;
        model(6'h18, 32'd1234567, 32'hFFFF_F000, h1, l1);
        model(6'h18, 32'h7FFF_FFFF, 32'd3, h2, l2);
        drive(1'b1, 6'h00, 6'h18, 32'd1234567, 32'hFFFF_F000);
        drive(1'b1, 6'h00, 6'h20, 32'd1, 32'd2);
        #1;
        checks++;
        if (md_stall !== 1'b0 || md_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_add stall=%b busy=%b want 0/1", md_stall, md_busy);
        end
        drive(1'b1, 6'h00, 6'h18, 32'h7FFF_FFFF, 32'd3);
        #1;
        n = 0;
        while (md_stall && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n !== 32 || md_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap stall cycles got %0d busy=%b want 32/0", n, md_busy);
        end
        checks++;
        if (md_hi !== h1 || md_lo !== l1) begin
            errors++;
            $display("FAIL b2b_first got %h/%h want %h/%h", md_hi, md_lo, h1, l1);
        end
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy=%b want 1", md_busy);
        end
        n = 0;
        while (md_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 33 || md_hi !== h2 || md_lo !== l2) begin
            errors++;
            $display("FAIL b2b_second n=%0d got %h/%h want 33 %h/%h",
                     n, md_hi, md_lo, h2, l2);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_random;
        logic [5:0] f;
        for (int i = 0; i < 24; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            run_md("random", f, pick_operand(), pick_operand());
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 6'h00, 6'h19, 32'hDEAD_BEEF, 32'h1234_5678);
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        repeat (15) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0 || md_hi !== 32'h0 || md_lo !== 32'h0 ||
            md_stall !== 1'b0) begin
            errors++;
            $display("FAIL async_reset busy=%b stall=%b hi=%h lo=%h want 0",
                     md_busy, md_stall, md_hi, md_lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_md("divu_after_reset", 6'h1B, 32'd9, 32'd3);
        checks++;
        if (md_lo !== 32'd3 || md_hi !== 32'd0) begin
            errors++;
            $display("FAIL divu_9_3 got %h/%h want 0/3", md_hi, md_lo);
        end
    endtask

    initial begin
        test_reset();
        // Hold HI/LO at a known nonzero value first so the reset check is meaningful
        test_vectors();
        test_mflo_stall();
        test_mt_mf();
        test_ignored();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
